ff_pipe: RTL and testbench



---
 rtl/ff_pkg.sv | 12 +
 rtl/ff_pipe_stage.sv | 34 +++
 rtl/ff_pipe.sv | 70 +++++++
 tb/tb_ff_pipe.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ff_pkg.sv
// Shared defaults and helpers for the elastic register pipeline.
package ff_pkg;

  localparam int unsigned DefWidth = 8;
  localparam int unsigned DefDepth = 2;

  // Bits needed to hold a count of 0..depth valid stages.
  function automatic int unsigned ff_cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ff_pipe_stage.sv
// One elastic stage: a valid/data register that loads whenever it is empty or
// the stage after it is draining, so bubbles collapse under a stall.
module ff_pipe_stage #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             prev_valid,
  input  logic [WIDTH-1:0] prev_data,
  input  logic             next_ready,
  output logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  assign ready = !valid || next_ready;

  // Stage register: flush drops the valid only, data is left untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (ready) begin
      valid <= prev_valid;
      if (prev_valid) begin
        data <= prev_data;
      end
    end
  end

endmodule

// File: rtl/ff_pipe.sv
// DEPTH-stage elastic register pipeline with valid/ready handshake, flush,
// per-stage taps and an occupancy count.
module ff_pipe
  import ff_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned DEPTH = DefDepth
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [WIDTH-1:0]            in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [WIDTH-1:0]            out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  input  logic                        flush,
  output logic [DEPTH*WIDTH-1:0]      tap_data,
  output logic [DEPTH-1:0]            tap_valid,
  output logic [ff_cnt_w(DEPTH)-1:0]  count
);

  localparam int unsigned CntW = ff_cnt_w(DEPTH);

  if (DEPTH < 1) begin : g_bad_depth
    $error("ff_pipe: DEPTH must be at least 1");
  end

  // Index 0 is the input side; index i+1 is the output of stage i.
  logic [DEPTH:0]   v_chain;
  logic [WIDTH-1:0] d_chain [DEPTH+1];
  // rdy[DEPTH] is the downstream consumer; rdy[i] is stage i accepting.
  logic [DEPTH:0]   rdy;

  assign v_chain[0] = in_valid;
  assign d_chain[0] = in_data;
  assign rdy[DEPTH] = out_ready;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    ff_pipe_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .prev_valid (v_chain[i]),
      .prev_data  (d_chain[i]),
      .next_ready (rdy[i+1]),
      .ready      (rdy[i]),
      .valid      (v_chain[i+1]),
      .data       (d_chain[i+1])
    );
    assign tap_data[i*WIDTH +: WIDTH] = d_chain[i+1];
  end

  // Combinational out_ready -> in_ready path through the ready chain.
  assign in_ready  = rdy[0] && !flush;
  assign out_valid = v_chain[DEPTH];
  assign out_data  = d_chain[DEPTH];
  assign tap_valid = v_chain[DEPTH:1];

  // Occupancy: number of stages holding a valid word.
  always_comb begin
    count = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count = count + CntW'(v_chain[i+1]);
    end
  end

endmodule

// File: tb/tb_ff_pipe.sv
// Self-checking bench: three ff_pipe configurations driven with directed and
// random traffic, checked against a slot-occupancy model plus an order scoreboard.
module tb_ff_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance 0: WIDTH=8 DEPTH=2
  logic        iv0, ir0, ov0, or0, fl0;
  logic [7:0]  id0, od0;
  logic [15:0] td0;
  logic [1:0]  tv0, c0;
  // Instance 1: WIDTH=8 DEPTH=3
  logic        iv1, ir1, ov1, or1, fl1;
  logic [7:0]  id1, od1;
  logic [23:0] td1;
  logic [2:0]  tv1;
  logic [1:0]  c1;
  // Instance 2: WIDTH=16 DEPTH=1
  logic        iv2, ir2, ov2, or2, fl2;
  logic [15:0] id2, od2, td2;
  logic [0:0]  tv2, c2;

  ff_pipe #(.WIDTH(8), .DEPTH(2)) u_d2 (
    .clk(clk), .rst(rst), .in_data(id0), .in_valid(iv0), .in_ready(ir0),
    .out_data(od0), .out_valid(ov0), .out_ready(or0), .flush(fl0),
    .tap_data(td0), .tap_valid(tv0), .count(c0)
  );
  ff_pipe #(.WIDTH(8), .DEPTH(3)) u_d3 (
    .clk(clk), .rst(rst), .in_data(id1), .in_valid(iv1), .in_ready(ir1),
    .out_data(od1), .out_valid(ov1), .out_ready(or1), .flush(fl1),
    .tap_data(td1), .tap_valid(tv1), .count(c1)
  );
  ff_pipe #(.WIDTH(16), .DEPTH(1)) u_d1 (
    .clk(clk), .rst(rst), .in_data(id2), .in_valid(iv2), .in_ready(ir2),
    .out_data(od2), .out_valid(ov2), .out_ready(or2), .flush(fl2),
    .tap_data(td2), .tap_valid(tv2), .count(c2)
  );

  // Stimulus per instance
  logic        iv [3];
  logic [15:0] id [3];
  logic        ordy [3];
  logic        fl [3];
  logic        acc [3];

  // Model: slot occupancy per instance plus the expected output order
  int unsigned dep [3] = '{2, 3, 1};
  int unsigned wid [3] = '{8, 8, 16};
  logic        mv [3][3];
  logic [15:0] md [3][3];
  logic [15:0] sbq [3][$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    iv0 = iv[0]; id0 = id[0][7:0]; or0 = ordy[0]; fl0 = fl[0];
    iv1 = iv[1]; id1 = id[1][7:0]; or1 = ordy[1]; fl1 = fl[1];
    iv2 = iv[2]; id2 = id[2];      or2 = ordy[2]; fl2 = fl[2];
  endtask

  task automatic idle_all();
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0; id[k] = '0; ordy[k] = 1'b1; fl[k] = 1'b0;
    end
  endtask

  task automatic model_clear(input int k);
    for (int i = 0; i < 3; i++) begin
      mv[k][i] = 1'b0;
      md[k][i] = '0;
    end
    sbq[k].delete();
  endtask

  task automatic check_model(input int k, input logic obs_ir, input logic obs_ov,
                             input logic [15:0] obs_od, input logic [2:0] obs_tv,
                             input logic [47:0] obs_td, input logic [1:0] obs_cnt);
    int d;
    int cnt;
    logic        e_ir;
    logic [2:0]  e_tv;
    logic [47:0] e_td;
    d = int'(dep[k]);
    cnt = 0;
    e_tv = '0;
    e_td = '0;
    for (int i = 0; i < d; i++) begin
      cnt += int'(mv[k][i]);
      e_tv[i] = mv[k][i];
      e_td = e_td | (48'(md[k][i]) << (i * int'(wid[k])));
    end
    // Something can enter iff any slot is free or the tail word is leaving.
    e_ir = !fl[k] && !rst && ((cnt < d) || ordy[k]);
    if (rst) e_ir = !fl[k];
    check($sformatf("d%0d_in_ready", d), obs_ir, e_ir);
    check($sformatf("d%0d_out_valid", d), obs_ov, mv[k][d-1]);
    check($sformatf("d%0d_out_data", d), obs_od, md[k][d-1]);
    check($sformatf("d%0d_tap_valid", d), obs_tv, e_tv);
    check($sformatf("d%0d_tap_data", d), obs_td, e_td);
    check($sformatf("d%0d_count", d), obs_cnt, cnt[1:0]);
    if (!rst && !fl[k] && mv[k][d-1] && ordy[k] && sbq[k].size() > 0)
      check($sformatf("d%0d_order", d), obs_od, sbq[k][0]);
  endtask

  task automatic check_all();
    check_model(0, ir0, ov0, {8'h0, od0}, {1'b0, tv0}, {32'h0, td0}, c0);
    check_model(1, ir1, ov1, {8'h0, od1}, tv1, {24'h0, td1}, c1);
    check_model(2, ir2, ov2, od2, {2'b0, tv2}, {32'h0, td2}, {1'b0, c2});
  endtask

  // Advance one clock of the model: the tail leaves if the consumer takes it,
  // then every word moves forward into any free slot ahead, then input fills slot 0.
  task automatic model_update(input int k);
    int d;
    d = int'(dep[k]);
    acc[k] = 1'b0;
    if (rst) begin
      model_clear(k);
      return;
    end
    if (fl[k]) begin
      for (int i = 0; i < 3; i++) mv[k][i] = 1'b0;
      sbq[k].delete();
      return;
    end
    if (mv[k][d-1] && ordy[k]) begin
      mv[k][d-1] = 1'b0;
      void'(sbq[k].pop_front());
    end
    for (int i = d - 1; i >= 1; i--) begin
      if (!mv[k][i] && mv[k][i-1]) begin
        mv[k][i]   = 1'b1;
        md[k][i]   = md[k][i-1];
        mv[k][i-1] = 1'b0;
      end
    end
    if (!mv[k][0] && iv[k]) begin
      mv[k][0] = 1'b1;
      md[k][0] = (wid[k] == 8) ? {8'h0, id[k][7:0]} : id[k];
      sbq[k].push_back(md[k][0]);
      acc[k] = 1'b1;
    end
  endtask

  // Starts and ends just after a falling edge.
  task automatic step();
    drive();
    #1;
    check_all();
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_update(k);
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] bp [3];
    int n;
    bp[0] = 8'hA1; bp[1] = 8'hA2; bp[2] = 8'hA3;

    // Reset state
    rst = 1'b1;
    idle_all();
    for (int k = 0; k < 3; k++) model_clear(k);
    drive();
    @(negedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b0;

    // Stream on DEPTH=2
    idle_all();
    iv[0] = 1'b1; id[0] = 16'h11; step();
    check("stream_tap0", td0[7:0], 8'h11);
    id[0] = 16'h22; step();
    check("stream_out1", od0, 8'h11);
    id[0] = 16'h33; step();
    check("stream_out2", od0, 8'h22);
    check("stream_count", c0, 2'd2);
    iv[0] = 1'b0;
    for (int s = 0; s < 3; s++) step();

    // Backpressure on DEPTH=2
    n = 0;
    ordy[0] = 1'b0;
    for (int s = 0; s < 4; s++) begin
      iv[0] = (n < 3); id[0] = {8'h0, (n < 3) ? bp[n] : 8'h00};
      step();
      if (acc[0]) n++;
    end
    check("bp_accepted", n, 2);
    check("bp_count", c0, 2'd2);
    drive();
    #1;
    check("bp_in_ready", ir0, 1'b0);
    ordy[0] = 1'b1;
    for (int s = 0; s < 10 && n < 3; s++) begin
      iv[0] = 1'b1; id[0] = {8'h0, bp[n]};
      step();
      if (acc[0]) n++;
    end
    check("bp_all_in", n, 3);
    iv[0] = 1'b0;
    for (int s = 0; s < 4; s++) step();

    // Bubble collapse on DEPTH=3
    ordy[1] = 1'b0;
    iv[1] = 1'b1; id[1] = 16'h05; step();
    iv[1] = 1'b0; step();
    iv[1] = 1'b1; id[1] = 16'h06; step();
    iv[1] = 1'b0;
    for (int s = 0; s < 3; s++) step();
    check("bubble_tap_valid", tv1, 3'b110);
    check("bubble_count", c1, 2'd2);
    check("bubble_out", od1, 8'h05);

    // Flush on a full DEPTH=3
    iv[1] = 1'b1; id[1] = 16'h07; step();
    check("flush_full", c1, 2'd3);
    fl[1] = 1'b1; id[1] = 16'h7F;
    drive();
    #1;
    check("flush_in_ready", ir1, 1'b0);
    step();
    fl[1] = 1'b0; iv[1] = 1'b0; ordy[1] = 1'b1;
    drive();
    #1;
    check("flush_count", c1, 2'd0);
    check("flush_out_valid", ov1, 1'b0);
    for (int s = 0; s < 4; s++) step();

    // DEPTH=1, alternating out_ready with continuous input
    for (int s = 0; s < 10; s++) begin
      iv[2] = 1'b1; id[2] = s[0] ? 16'h5678 : 16'h1234; ordy[2] = s[0];
      step();
    end
    idle_all();
    step();

    // Random traffic on all three
    for (int s = 0; s < 600; s++) begin
      for (int k = 0; k < 3; k++) begin
        iv[k]   = ($urandom_range(0, 9) < 7);
        id[k]   = 16'($urandom);
        ordy[k] = ($urandom_range(0, 9) < ((s < 300) ? 6 : 3));
        fl[k]   = ($urandom_range(0, 24) == 0);
      end
      step();
    end

    // Asynchronous reset mid-stream
    idle_all();
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b1; ordy[k] = 1'b0; id[k] = 16'h00C0 + 16'(k);
    end
    step();
    step();
    check("pre_rst_count", c0, 2'd2);
    idle_all();
    drive();
    #2;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) model_clear(k);
    #1;
    check("rst_out_valid", ov0, 1'b0);
    check("rst_count", c0, 2'd0);
    check("rst_tap_valid", tv0, 2'b00);
    check_all();
    @(negedge clk);
    step();
    rst = 1'b0;
    iv[0] = 1'b1; id[0] = 16'h3C; step();
    iv[0] = 1'b0; step();
    check("rst_lat_valid", ov0, 1'b1);
    check("rst_lat_data", od0, 8'h3C);
    for (int s = 0; s < 3; s++) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
